mux_eight_to_one: RTL and testbench
===================================

Name: mux_eight_to_one

Overview:
- Bit-select 8:1 multiplexer used as a generic datapath steering primitive.
- Provides a combinational output OUT that follows the inputs with zero cycles of latency.
- Provides a registered copy OUT_REG for timing-critical consumers. OUT_REG is clocked on clk and reset asynchronously by active-low rst_n.

Parameters:
- WIDTH, 1, bit width of each data input and of both outputs.

Ports:
- clk  input  1  system clock; rising edge samples OUT_REG.
- rst_n  input  1  asynchronous active-low reset.
- in0  input  WIDTH  data input selected when {s2,s1,s0}=3'b000.
- in1  input  WIDTH  data input selected when select=3'b001.
- in2  input  WIDTH  data input selected when select=3'b010.
- in3  input  WIDTH  data input selected when select=3'b011.
- in4  input  WIDTH  data input selected when select=3'b100.
- in5  input  WIDTH  data input selected when select=3'b101.
- in6  input  WIDTH  data input selected when select=3'b110.
- in7  input  WIDTH  data input selected when select=3'b111.
- s0  input  1  select bit 0 (LSB).
- s1  input  1  select bit 1.
- s2  input  1  select bit 2 (MSB).
- OUT  output  WIDTH  combinational selected data.
- OUT_REG  output  WIDTH  OUT registered on the rising edge of clk.

Interface note (already decided): one clock; reset is asynchronous and active-low. The clock port is clk and the reset port is rst_n.

Behaviour:
- Select index sel = {s2,s1,s0}. OUT = in[sel] at all times.
- OUT is purely combinational: no dependence on clk or rst_n, zero latency.
- OUT updates whenever any input or select bit changes.
- All eight select codes are legal; there is no default or invalid code.
- OUT_REG loads OUT on every rising edge of clk while rst_n=1. Latency is 1 cycle; there is no enable.
- rst_n=0 forces OUT_REG to all zeros immediately, regardless of clk.
- Release of rst_n is synchronous in effect: OUT_REG loads on the first rising clk edge after rst_n=1.
- Reset does not affect OUT. OUT stays valid during reset.
- Simultaneous select and data change: OUT reflects the new select applied to the new data after settling. No glitch-free guarantee.
- X/Z on any select bit: OUT is X in simulation. Synthesis may pick any input.
- Widths are strictly WIDTH on every data port. There is no truncation or extension.

Decomposition:
- Shared package: localparam SEL_W=3 and NUM_IN=8, plus select-code constants SEL_IN0..SEL_IN7 (3'd0..3'd7).
- One natural sub-module, four_to_one_mux (WIDTH-parameterised, 2-bit select), instantiated twice:
  - Lower instance: in0..in3 with {s1,s0}.
  - Upper instance: in4..in7 with {s1,s0}.
  - A final 2:1 stage on s2 selects between the two instances.
- The output register lives in the top level.

Test Plan:
1. For each sel 0..7, with WIDTH=1, drive in[sel]=0 and all other inputs 1 -> OUT=0. Then drive in[sel]=1 and all others 0 -> OUT=1. This proves isolation of each input.
2. Reset check: hold rst_n=0 with sel=3'b101 and in5=1 -> OUT=1 immediately and OUT_REG=0. Release rst_n -> OUT_REG=1 after the first rising clk edge.
3. Async reset mid-operation:
   - Set OUT_REG=1 via sel=3'b111, in7=1.
   - Assert rst_n=0 between clock edges -> OUT_REG=0 without waiting for a clk edge, while OUT stays 1.
4. Latency check: with clk running, switch sel from 3'b000 (in0=0) to 3'b011 (in3=1) -> OUT=1 in the same cycle. OUT_REG=0 until the next rising edge, then OUT_REG=1.
5. WIDTH=8 instance:
   - Set in0..in7 = 8'h10, 8'h21, 8'h32, 8'h43, 8'h54, 8'h65, 8'h76, 8'h87.
   - Sweep sel 0..7 -> OUT steps 8'h10, 8'h21, … 8'h87.
   - OUT_REG trails OUT by one cycle.
6. Data change with select fixed: sel=3'b010, toggle in2 0->1->0 while all other inputs toggle opposite -> OUT tracks in2 exactly.

Source files
------------

// File: rtl/mux_eight_to_one_pkg.sv
// ---------------------------------------------------------------------------
// mux_eight_to_one_pkg
// Shared constants for the 8:1 bit-select multiplexer and its 4:1 leaf.
//   SEL_W / NUM_IN : width of the full select and number of data inputs
//   SUB_SEL_W      : select width seen by each 4:1 leaf ({s1,s0})
//   SEL_IN0..7     : select code that steers the matching data input
// ---------------------------------------------------------------------------
package mux_eight_to_one_pkg;

    localparam int SEL_W     = 3;
    localparam int NUM_IN    = 8;
    localparam int SUB_SEL_W = SEL_W - 1;

    typedef logic [SEL_W-1:0]     sel_t;
    typedef logic [SUB_SEL_W-1:0] sub_sel_t;

    localparam sel_t SEL_IN0 = 3'd0;
    localparam sel_t SEL_IN1 = 3'd1;
    localparam sel_t SEL_IN2 = 3'd2;
    localparam sel_t SEL_IN3 = 3'd3;
    localparam sel_t SEL_IN4 = 3'd4;
    localparam sel_t SEL_IN5 = 3'd5;
    localparam sel_t SEL_IN6 = 3'd6;
    localparam sel_t SEL_IN7 = 3'd7;

    // MSB of the select chooses between the lower (in0..in3) and upper
    // (in4..in7) leaf; the remaining bits go to both leaves unchanged.
    function automatic logic sel_upper(input sel_t sel);
        return sel[SEL_W-1];
    endfunction

    function automatic sub_sel_t sel_leaf(input sel_t sel);
        return sel[SUB_SEL_W-1:0];
    endfunction

endpackage

// File: rtl/mux_eight_to_one_four_to_one_mux.sv
// ---------------------------------------------------------------------------
// four_to_one_mux
// Combinational 4:1 leaf used twice by mux_eight_to_one.
//   i_d0..i_d3 : WIDTH-bit data inputs
//   i_sel      : 2-bit select, i_d[i_sel] is forwarded
//   o_y        : WIDTH-bit selected data
// ---------------------------------------------------------------------------
module four_to_one_mux
    import mux_eight_to_one_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] i_d0,
    input  logic [WIDTH-1:0] i_d1,
    input  logic [WIDTH-1:0] i_d2,
    input  logic [WIDTH-1:0] i_d3,
    input  sub_sel_t         i_sel,
    output logic [WIDTH-1:0] o_y
);

    logic [WIDTH-1:0] w_lo;
    logic [WIDTH-1:0] w_hi;

    // Ternary tree rather than a case: an X on a select bit then merges
    // the candidates in simulation instead of silently picking a default.
    assign w_lo = i_sel[0] ? i_d1 : i_d0;
    assign w_hi = i_sel[0] ? i_d3 : i_d2;
    assign o_y  = i_sel[1] ? w_hi : w_lo;

endmodule

// File: rtl/mux_eight_to_one.sv
// ---------------------------------------------------------------------------
// mux_eight_to_one
// Bit-select 8:1 steering multiplexer with a combinational and a registered
// output.
//   clk      : system clock, rising edge loads OUT_REG
//   rst_n    : asynchronous active-low reset, clears OUT_REG only
//   in0..in7 : WIDTH-bit data inputs
//   s0,s1,s2 : select bits, sel = {s2,s1,s0}
//   OUT      : in[sel], zero latency, independent of clk/rst_n
//   OUT_REG  : OUT delayed by one clk cycle, zero while rst_n is low
// ---------------------------------------------------------------------------
module mux_eight_to_one
    import mux_eight_to_one_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic [WIDTH-1:0] in4,
    input  logic [WIDTH-1:0] in5,
    input  logic [WIDTH-1:0] in6,
    input  logic [WIDTH-1:0] in7,
    input  logic             s0,
    input  logic             s1,
    input  logic             s2,
    output logic [WIDTH-1:0] OUT,
    output logic [WIDTH-1:0] OUT_REG
);

    sel_t             w_sel;
    logic [WIDTH-1:0] w_lower;
    logic [WIDTH-1:0] w_upper;
    logic [WIDTH-1:0] r_out;

    assign w_sel = {s2, s1, s0};

    // Both leaves see the same low select bits; s2 picks the leaf below.
    four_to_one_mux #(
        .WIDTH (WIDTH)
    ) u_lower (
        .i_d0  (in0),
        .i_d1  (in1),
        .i_d2  (in2),
        .i_d3  (in3),
        .i_sel (sel_leaf(w_sel)),
        .o_y   (w_lower)
    );

    four_to_one_mux #(
        .WIDTH (WIDTH)
    ) u_upper (
        .i_d0  (in4),
        .i_d1  (in5),
        .i_d2  (in6),
        .i_d3  (in7),
        .i_sel (sel_leaf(w_sel)),
        .o_y   (w_upper)
    );

    assign OUT = sel_upper(w_sel) ? w_upper : w_lower;

    // Stage boundary: combinational result -> registered copy.
    // Reset clears immediately; after release the first rising edge loads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out <= '0;
        end else begin
            r_out <= OUT;
        end
    end

    assign OUT_REG = r_out;

endmodule

// File: tb/tb_mux_eight_to_one.sv
module tb_mux_eight_to_one;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [2:0] sel   = 3'd0;
    logic       s0, s1, s2;
    logic [7:0] d1    = 8'h00;   // bit i drives in<i> of the WIDTH=1 instance
    logic [7:0] d8 [8];          // in0..in7 of the WIDTH=8 instance
    logic       out1, oreg1;
    logic [7:0] out8, oreg8;
    logic       exp_reg1;
    logic [7:0] exp_reg8;
    logic       chk_en = 1'b0;
    int         n_cmp  = 0;
    int         n_bad  = 0;

    assign s0 = sel[0];
    assign s1 = sel[1];
    assign s2 = sel[2];

    always #5 clk = ~clk;

    mux_eight_to_one #(.WIDTH(1)) u_w1 (
        .clk (clk), .rst_n (rst_n),
        .in0 (d1[0]), .in1 (d1[1]), .in2 (d1[2]), .in3 (d1[3]),
        .in4 (d1[4]), .in5 (d1[5]), .in6 (d1[6]), .in7 (d1[7]),
        .s0 (s0), .s1 (s1), .s2 (s2),
        .OUT (out1), .OUT_REG (oreg1)
    );

    mux_eight_to_one #(.WIDTH(8)) u_w8 (
        .clk (clk), .rst_n (rst_n),
        .in0 (d8[0]), .in1 (d8[1]), .in2 (d8[2]), .in3 (d8[3]),
        .in4 (d8[4]), .in5 (d8[5]), .in6 (d8[6]), .in7 (d8[7]),
        .s0 (s0), .s1 (s1), .s2 (s2),
        .OUT (out8), .OUT_REG (oreg8)
    );

    // Reference: the registered output is whichever input the select named
    // just before the last rising edge, or zero while/after reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_reg1 <= 1'b0;
            exp_reg8 <= 8'h00;
        end else begin
            exp_reg1 <= d1[sel];
            exp_reg8 <= d8[sel];
        end
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_out_w1",  {7'd0, out1},  {7'd0, d1[sel]});
            chk("cyc_out_w8",  out8,          d8[sel]);
            chk("cyc_reg_w1",  {7'd0, oreg1}, {7'd0, exp_reg1});
            chk("cyc_reg_w8",  oreg8,         exp_reg8);
        end
    end

    task automatic slot();
        @(negedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) d8[i] = 8'h00;
        #2 rst_n = 1'b0;
        #1;
        chk("reset_reg_w1", {7'd0, oreg1}, 8'h00);
        chk("reset_reg_w8", oreg8, 8'h00);
        chk_en = 1'b1;

        // Reset held: OUT live, OUT_REG zero, release loads on next edge.
        slot();
        sel = 3'b101; d1 = 8'h20;
        #1;
        chk("rst_out_live", {7'd0, out1}, 8'h01);
        chk("rst_reg_zero", {7'd0, oreg1}, 8'h00);
        slot();
        rst_n = 1'b1;
        #1;
        chk("rel_before_edge", {7'd0, oreg1}, 8'h00);
        @(posedge clk); #1;
        chk("rel_after_edge", {7'd0, oreg1}, 8'h01);

        // Isolation of each input at WIDTH=1.
        for (int s = 0; s < 8; s++) begin
            slot();
            sel = s[2:0];
            d1 = ~(8'h01 << s);
            #1;
            chk($sformatf("iso0_sel%0d", s), {7'd0, out1}, 8'h00);
            d1 = 8'h01 << s;
            #1;
            chk($sformatf("iso1_sel%0d", s), {7'd0, out1}, 8'h01);
        end

        // Asynchronous reset between edges.
        slot();
        sel = 3'b111; d1 = 8'h80;
        @(posedge clk); #1;
        chk("async_pre_reg", {7'd0, oreg1}, 8'h01);
        #1 rst_n = 1'b0;
        #1;
        chk("async_reg_clr", {7'd0, oreg1}, 8'h00);
        chk("async_out_held", {7'd0, out1}, 8'h01);
        slot();
        rst_n = 1'b1;

        // Latency: OUT same cycle, OUT_REG one edge later.
        slot();
        sel = 3'b000; d1 = 8'h00;
        @(posedge clk);
        slot();
        sel = 3'b011; d1 = 8'h08;
        #1;
        chk("lat_out_now", {7'd0, out1}, 8'h01);
        chk("lat_reg_old", {7'd0, oreg1}, 8'h00);
        @(posedge clk); #1;
        chk("lat_reg_new", {7'd0, oreg1}, 8'h01);

        // WIDTH=8 sweep.
        slot();
        for (int i = 0; i < 8; i++) d8[i] = 8'h10 + 8'(i * 8'h11);
        for (int i = 0; i < 8; i++) begin
            slot();
            sel = i[2:0];
            #1;
            chk($sformatf("w8_out_sel%0d", i), out8, 8'h10 + 8'(i * 8'h11));
            @(posedge clk); #1;
            chk($sformatf("w8_reg_sel%0d", i), oreg8, 8'h10 + 8'(i * 8'h11));
        end

        // Data toggles with select fixed at 2.
        slot();
        sel = 3'b010;
        d1 = 8'hFB; d8[2] = 8'h00;
        #1;
        chk("tog_a", {7'd0, out1}, 8'h00);
        d1 = 8'h04; d8[2] = 8'hA5;
        #1;
        chk("tog_b", {7'd0, out1}, 8'h01);
        chk("tog_b_w8", out8, 8'hA5);
        d1 = 8'hFB;
        #1;
        chk("tog_c", {7'd0, out1}, 8'h00);

        // Randomized traffic with occasional mid-cycle reset pulses.
        for (int n = 0; n < 400; n++) begin
            slot();
            sel = 3'($urandom_range(0, 7));
            d1  = 8'($urandom);
            for (int i = 0; i < 8; i++) d8[i] = 8'($urandom);
            rst_n = ($urandom_range(0, 29) != 0);
        end
        slot();
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        slot();
        chk_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
